// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the in-order store buffer.
package store_buffer_pkg;

    localparam int unsigned SB_ENTRY    = 8;
    localparam int unsigned WORD_SIZE_P = 16;
    localparam int unsigned SB_IDX_W    = $clog2(SB_ENTRY);
    localparam int unsigned SB_PTR_W    = SB_IDX_W + 1;

    typedef enum logic [1:0] {
        SB_FREE,
        SB_ALLOC,
        SB_READY,
        SB_COMMITTED
    } sb_state_e;

    typedef struct packed {
        logic [SB_IDX_W-1:0]    sb_dest;
        logic [WORD_SIZE_P-1:0] address;
        logic [WORD_SIZE_P-1:0] result;
    } CDB_sb_t;

    localparam int unsigned CDB_SB_WIDTH = $bits(CDB_sb_t);

endpackage

// File: rtl/sb_age_match.sv
// Circular priority select: youngest hit among candidates in [head, tag).
module sb_age_match
    import store_buffer_pkg::*;
(
    input  logic [SB_IDX_W-1:0] head,
    input  logic [SB_IDX_W-1:0] tag,
    input  logic [SB_ENTRY-1:0] cand,
    input  logic [SB_ENTRY-1:0] hit,
    output logic [SB_ENTRY-1:0] sel_oh,
    output logic                found
);

    logic [SB_IDX_W-1:0] span;
    logic [SB_IDX_W-1:0] idx;

    // Walk oldest to youngest so the last qualifying hit wins.
    always_comb begin
        sel_oh = '0;
        found  = 1'b0;
        idx    = '0;
        span   = tag - head;
        for (int unsigned k = 0; k < SB_ENTRY; k++) begin
            idx = head + SB_IDX_W'(k);
            if ((SB_IDX_W'(k) < span) && cand[idx] && hit[idx]) begin
                sel_oh      = '0;
                sel_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular in-order store buffer with commit, memory drain and load bypass.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   alloc_v_i,
    output logic [SB_IDX_W-1:0]    alloc_sb_num_o,
    output logic                   full_o,
    output logic                   empty_o,
    input  logic                   lsu_sb_v_i,
    input  CDB_sb_t                lsu_sb_i,
    input  logic [WORD_SIZE_P-1:0] exe_ld_bypass_addr_i,
    input  logic [SB_IDX_W-1:0]    exe_ld_bypass_sb_num_i,
    output logic                   sb_ld_bypass_valid_o,
    output logic [WORD_SIZE_P-1:0] sb_ld_bypass_value_o,
    output logic                   sb_ld_bypass_hazard_o,
    input  logic                   commit_v_i,
    output logic                   mem_w_v_o,
    output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_w_data_o,
    input  logic                   mem_w_ready_i,
    input  logic                   mispredict_i
);

    sb_state_e              state_q [SB_ENTRY];
    sb_state_e              state_d [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] addr_q  [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] data_q  [SB_ENTRY];
    logic [SB_PTR_W-1:0]    head_q, cptr_q, tail_q;
    logic [SB_PTR_W-1:0]    head_d, cptr_d, tail_d;
    logic [SB_IDX_W-1:0]    head_idx, cptr_idx, tail_idx, off;
    logic [SB_PTR_W-1:0]    squash_cnt;
    logic                   wr_ok, commit_ok, drain_ok, alloc_ok;
    logic [SB_ENTRY-1:0]    fwd, cand, hit, sel_oh;
    logic                   found;

    assign head_idx = head_q[SB_IDX_W-1:0];
    assign cptr_idx = cptr_q[SB_IDX_W-1:0];
    assign tail_idx = tail_q[SB_IDX_W-1:0];

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= '{default: SB_FREE};
            head_q  <= '0;
            cptr_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cptr_q  <= cptr_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage is only observed through non-FREE entries, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            addr_q[lsu_sb_i.sb_dest] <= lsu_sb_i.address;
            data_q[lsu_sb_i.sb_dest] <= lsu_sb_i.result;
        end
    end

    // Next state: write, commit, drain, alloc, then squash from the post-commit cptr.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        cptr_d     = cptr_q;
        tail_d     = tail_q;
        off        = '0;
        squash_cnt = '0;
        wr_ok      = lsu_sb_v_i && !mispredict_i && (state_q[lsu_sb_i.sb_dest] == SB_ALLOC);
        commit_ok  = commit_v_i && (cptr_q != tail_q) && (state_q[cptr_idx] == SB_READY);
        drain_ok   = (state_q[head_idx] == SB_COMMITTED) && mem_w_ready_i;
        alloc_ok   = alloc_v_i && !full_o && !mispredict_i;

        if (wr_ok) state_d[lsu_sb_i.sb_dest] = SB_READY;
        if (commit_ok) begin
            state_d[cptr_idx] = SB_COMMITTED;
            cptr_d            = cptr_q + SB_PTR_W'(1);
        end
        if (drain_ok) begin
            state_d[head_idx] = SB_FREE;
            head_d            = head_q + SB_PTR_W'(1);
        end
        if (alloc_ok) begin
            state_d[tail_idx] = SB_ALLOC;
            tail_d            = tail_q + SB_PTR_W'(1);
        end
        if (mispredict_i) begin
            squash_cnt = tail_q - cptr_d;
            for (int unsigned i = 0; i < SB_ENTRY; i++) begin
                off = SB_IDX_W'(i) - cptr_d[SB_IDX_W-1:0];
                if (SB_PTR_W'(off) < squash_cnt) state_d[i] = SB_FREE;
            end
            tail_d = cptr_d;
        end
    end

    // An unresolved (ALLOC) entry may alias any load address, so it always counts as a hit.
    always_comb begin
        fwd  = '0;
        cand = '0;
        hit  = '0;
        for (int unsigned i = 0; i < SB_ENTRY; i++) begin
            fwd[i]  = lsu_sb_v_i && (lsu_sb_i.sb_dest == SB_IDX_W'(i)) && (state_q[i] == SB_ALLOC);
            cand[i] = (state_q[i] != SB_FREE);
            hit[i]  = ((state_q[i] == SB_ALLOC) && !fwd[i])
                   || ((fwd[i] ? lsu_sb_i.address : addr_q[i]) == exe_ld_bypass_addr_i);
        end
    end

    sb_age_match u_age_match (
        .head   (head_idx),
        .tag    (exe_ld_bypass_sb_num_i),
        .cand   (cand),
        .hit    (hit),
        .sel_oh (sel_oh),
        .found  (found)
    );

    // Outputs: status flags, drain port and bypass result.
    always_comb begin
        full_o                = (head_idx == tail_idx) && (head_q[SB_IDX_W] != tail_q[SB_IDX_W]);
        empty_o               = (head_q == tail_q);
        alloc_sb_num_o        = tail_idx;
        mem_w_v_o             = (state_q[head_idx] == SB_COMMITTED);
        mem_w_addr_o          = mem_w_v_o ? addr_q[head_idx] : '0;
        mem_w_data_o          = mem_w_v_o ? data_q[head_idx] : '0;
        sb_ld_bypass_valid_o  = 1'b0;
        sb_ld_bypass_hazard_o = 1'b0;
        sb_ld_bypass_value_o  = '0;
        if (found) begin
            for (int unsigned i = 0; i < SB_ENTRY; i++) begin
                if (sel_oh[i]) begin
                    if ((state_q[i] == SB_ALLOC) && !fwd[i]) begin
                        sb_ld_bypass_hazard_o = 1'b1;
                    end else begin
                        sb_ld_bypass_valid_o = 1'b1;
                        sb_ld_bypass_value_o = fwd[i] ? lsu_sb_i.result : data_q[i];
                    end
                end
            end
        end
    end

    a_alloc_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(alloc_v_i && full_o)) else $error("alloc while full");
    a_write_state: assert property (@(posedge clk_i) disable iff (reset_i)
        !(lsu_sb_v_i && (state_q[lsu_sb_i.sb_dest] != SB_ALLOC))) else $error("lsu write to non-ALLOC entry");
    a_commit_state: assert property (@(posedge clk_i) disable iff (reset_i)
        !(commit_v_i && ((cptr_q == tail_q) || (state_q[cptr_idx] == SB_ALLOC)))) else $error("illegal commit");

endmodule
